rob_update_queue: RTL and testbench

- Completion-side producer for the ROB update port (dup1_req/dup2_req, rob_idx_in1/2, bt_ex_in1/2, ba_ex_in1/2).
- Buffers execute-stage completions in a circular queue and drains up to two per cycle into the ROB, oldest first.
- Sits between the functional-unit completion buses and the ROB.
- Flushes on ROB branch_miss.

---
 rtl/rob_update_queue_if.sv | 51 +++++
 rtl/rob_update_queue.sv | 119 +++++++++++
 tb/tb_rob_update_queue.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rob_update_queue_if.sv
// ============================================================================
//  Module      : rob_update_queue_if
//  Description : Completion-bus / ROB-update bundle for rob_update_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ROB_IDX
`define ROB_IDX 6
`endif

interface rob_update_queue_if #(
    parameter int ROB_IDX = `ROB_IDX,
    parameter int QIDX    = 3
);
    logic               branch_miss;
    logic               cmp1_valid;
    logic               cmp2_valid;
    logic [ROB_IDX-1:0] cmp1_rob_idx;
    logic [ROB_IDX-1:0] cmp2_rob_idx;
    logic               cmp1_bt;
    logic               cmp2_bt;
    logic [63:0]        cmp1_ba;
    logic [63:0]        cmp2_ba;
    logic               cmp_ready;
    logic               dup1_req;
    logic               dup2_req;
    logic [ROB_IDX-1:0] rob_idx_out1;
    logic [ROB_IDX-1:0] rob_idx_out2;
    logic               bt_ex_out1;
    logic               bt_ex_out2;
    logic [63:0]        ba_ex_out1;
    logic [63:0]        ba_ex_out2;
    logic [QIDX:0]      count;

    modport master (
        output branch_miss, cmp1_valid, cmp2_valid, cmp1_rob_idx, cmp2_rob_idx,
               cmp1_bt, cmp2_bt, cmp1_ba, cmp2_ba,
        input  cmp_ready, dup1_req, dup2_req, rob_idx_out1, rob_idx_out2,
               bt_ex_out1, bt_ex_out2, ba_ex_out1, ba_ex_out2, count
    );

    modport slave (
        input  branch_miss, cmp1_valid, cmp2_valid, cmp1_rob_idx, cmp2_rob_idx,
               cmp1_bt, cmp2_bt, cmp1_ba, cmp2_ba,
        output cmp_ready, dup1_req, dup2_req, rob_idx_out1, rob_idx_out2,
               bt_ex_out1, bt_ex_out2, ba_ex_out1, ba_ex_out2, count
    );
endinterface

`default_nettype wire

// File: rtl/rob_update_queue.sv
// ============================================================================
//  Module      : rob_update_queue
//  Description : Circular queue buffering execute completions; drains up to
//                two per cycle into the ROB update port, oldest first.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ROB_IDX
`define ROB_IDX 6
`endif

module rob_update_queue #(
    parameter int QDEPTH  = 8,
    parameter int QIDX    = 3,
    parameter int ROB_IDX = `ROB_IDX
) (
    input  wire                  clk,
    input  wire                  reset,
    rob_update_queue_if.slave    bus
);

    localparam logic [QIDX:0] c_ready_max = (QIDX+1)'(QDEPTH - 2);
    localparam logic [QIDX:0] c_two       = (QIDX+1)'(2);

    logic [ROB_IDX-1:0] r_ent_idx [QDEPTH];
    logic               r_ent_bt  [QDEPTH];
    logic [63:0]        r_ent_ba  [QDEPTH];
    logic [QIDX-1:0]    r_head;
    logic [QIDX-1:0]    r_tail;
    logic [QIDX:0]      r_count;

    logic               w_cmp_ready;
    logic               w_accept;
    logic               w_dup1;
    logic               w_dup2;
    logic [1:0]         w_n_in;
    logic [1:0]         w_n_out;
    logic [QIDX-1:0]    w_head1;
    logic [QIDX-1:0]    w_tail1;
    logic               w_wr0;
    logic               w_wr1;
    logic [ROB_IDX-1:0] w_wr0_idx;
    logic               w_wr0_bt;
    logic [63:0]        w_wr0_ba;

    always_comb begin
        w_cmp_ready = (r_count <= c_ready_max);
        w_accept    = w_cmp_ready & ~bus.branch_miss;
        w_n_in      = w_accept ? ({1'b0, bus.cmp1_valid} + {1'b0, bus.cmp2_valid}) : 2'd0;
        w_dup1      = (r_count != '0) & ~bus.branch_miss;
        w_dup2      = (r_count >= c_two) & ~bus.branch_miss;
        w_n_out     = {1'b0, w_dup1} + {1'b0, w_dup2};
        w_head1     = r_head + QIDX'(1);
        w_tail1     = r_tail + QIDX'(1);
        // A lone slot-2 completion is compacted into the tail position.
        w_wr0       = w_accept & (bus.cmp1_valid | bus.cmp2_valid);
        w_wr1       = w_accept & bus.cmp1_valid & bus.cmp2_valid;
        w_wr0_idx   = bus.cmp1_valid ? bus.cmp1_rob_idx : bus.cmp2_rob_idx;
        w_wr0_bt    = bus.cmp1_valid ? bus.cmp1_bt      : bus.cmp2_bt;
        w_wr0_ba    = bus.cmp1_valid ? bus.cmp1_ba      : bus.cmp2_ba;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.branch_miss) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + QIDX'(w_n_out);
            r_tail  <= r_tail + QIDX'(w_n_in);
            r_count <= r_count + (QIDX+1)'(w_n_in) - (QIDX+1)'(w_n_out);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_ent_idx[i] <= '0;
                r_ent_bt[i]  <= 1'b0;
                r_ent_ba[i]  <= '0;
            end
        end else begin
            if (w_wr0) begin
                r_ent_idx[r_tail] <= w_wr0_idx;
                r_ent_bt[r_tail]  <= w_wr0_bt;
                r_ent_ba[r_tail]  <= w_wr0_ba;
            end
            if (w_wr1) begin
                r_ent_idx[w_tail1] <= bus.cmp2_rob_idx;
                r_ent_bt[w_tail1]  <= bus.cmp2_bt;
                r_ent_ba[w_tail1]  <= bus.cmp2_ba;
            end
        end
    end

    always_comb begin
        bus.cmp_ready    = w_cmp_ready;
        bus.count        = r_count;
        bus.dup1_req     = w_dup1;
        bus.dup2_req     = w_dup2;
        bus.rob_idx_out1 = w_dup1 ? r_ent_idx[r_head]  : '0;
        bus.bt_ex_out1   = w_dup1 ? r_ent_bt[r_head]   : 1'b0;
        bus.ba_ex_out1   = w_dup1 ? r_ent_ba[r_head]   : '0;
        bus.rob_idx_out2 = w_dup2 ? r_ent_idx[w_head1] : '0;
        bus.bt_ex_out2   = w_dup2 ? r_ent_bt[w_head1]  : 1'b0;
        bus.ba_ex_out2   = w_dup2 ? r_ent_ba[w_head1]  : '0;
    end

    a_count_range: assert property (@(posedge clk) disable iff (reset)
        r_count <= (QIDX+1)'(QDEPTH));

endmodule

`default_nettype wire

// File: tb/tb_rob_update_queue.sv
// ============================================================================
//  Module      : tb_rob_update_queue
//  Description : Randomized bench for rob_update_queue against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rob_update_queue;

    localparam int RI     = 6;
    localparam int QDEPTH = 8;
    localparam int QIDX   = 3;

    typedef struct {
        logic [RI-1:0] idx;
        logic          bt;
        logic [63:0]   ba;
    } ent_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    ent_t mq[$];
    int   m_tail;

    rob_update_queue_if #(.ROB_IDX(RI), .QIDX(QIDX)) u_if ();

    rob_update_queue #(.QDEPTH(QDEPTH), .QIDX(QIDX), .ROB_IDX(RI)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        u_if.branch_miss  = 1'b0;
        u_if.cmp1_valid   = 1'b0;
        u_if.cmp2_valid   = 1'b0;
        u_if.cmp1_rob_idx = '0;
        u_if.cmp2_rob_idx = '0;
        u_if.cmp1_bt      = 1'b0;
        u_if.cmp2_bt      = 1'b0;
        u_if.cmp1_ba      = '0;
        u_if.cmp2_ba      = '0;
    endtask

    // One cycle: drive at negedge, check against model, advance model at posedge.
    task automatic step(input logic v1, input logic v2, input int i1, input int i2,
                        input logic b1, input logic b2, input logic [63:0] a1,
                        input logic [63:0] a2, input logic bm);
        ent_t e1, e2, z;
        int   sz, n_out;
        logic rdy, d1, d2;
        u_if.cmp1_valid   = v1;
        u_if.cmp2_valid   = v2;
        u_if.cmp1_rob_idx = RI'(i1);
        u_if.cmp2_rob_idx = RI'(i2);
        u_if.cmp1_bt      = b1;
        u_if.cmp2_bt      = b2;
        u_if.cmp1_ba      = a1;
        u_if.cmp2_ba      = a2;
        u_if.branch_miss  = bm;
        #1;
        z  = '{idx: '0, bt: 1'b0, ba: '0};
        sz = mq.size();
        rdy = (sz <= QDEPTH - 2);
        d1 = (sz >= 1) && !bm;
        d2 = (sz >= 2) && !bm;
        e1 = d1 ? mq[0] : z;
        e2 = d2 ? mq[1] : z;
        check("count",     64'(u_if.count),        64'(sz));
        check("cmp_ready", 64'(u_if.cmp_ready),    64'(rdy));
        check("dup1_req",  64'(u_if.dup1_req),     64'(d1));
        check("dup2_req",  64'(u_if.dup2_req),     64'(d2));
        check("rob_idx1",  64'(u_if.rob_idx_out1), 64'(e1.idx));
        check("bt1",       64'(u_if.bt_ex_out1),   64'(e1.bt));
        check("ba1",       u_if.ba_ex_out1,        e1.ba);
        check("rob_idx2",  64'(u_if.rob_idx_out2), 64'(e2.idx));
        check("bt2",       64'(u_if.bt_ex_out2),   64'(e2.bt));
        check("ba2",       u_if.ba_ex_out2,        e2.ba);
        @(posedge clk);
        if (bm) begin
            mq.delete();
            m_tail = 0;
        end else begin
            n_out = int'(d1) + int'(d2);
            repeat (n_out) void'(mq.pop_front());
            if (rdy) begin
                if (v1) begin mq.push_back('{idx: RI'(i1), bt: b1, ba: a1}); m_tail = (m_tail + 1) % QDEPTH; end
                if (v2) begin mq.push_back('{idx: RI'(i2), bt: b2, ba: a2}); m_tail = (m_tail + 1) % QDEPTH; end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 64'd0, 64'd0, 0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        check("arst_count", 64'(u_if.count),     64'd0);
        check("arst_dup1",  64'(u_if.dup1_req),  64'd0);
        check("arst_dup2",  64'(u_if.dup2_req),  64'd0);
        check("arst_rdy",   64'(u_if.cmp_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        m_tail = 0;
    endtask

    task automatic rand_step(input int bm_odds);
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(0, bm_odds - 1) == 0));
    endtask

    initial begin
        int k;
        logic two;
        n_tests = 0;
        n_fail  = 0;
        m_tail  = 0;
        reset   = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("rst_count", 64'(u_if.count),        64'd0);
        check("rst_rdy",   64'(u_if.cmp_ready),    64'd1);
        check("rst_dup1",  64'(u_if.dup1_req),     64'd0);
        check("rst_dup2",  64'(u_if.dup2_req),     64'd0);
        check("rst_idx1",  64'(u_if.rob_idx_out1), 64'd0);
        check("rst_ba1",   u_if.ba_ex_out1,        64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single completion, then drain.
        step(1, 0, 5, 0, 1, 0, 64'd100, 64'd0, 0);
        check("t1_idx_const", 64'(u_if.rob_idx_out1), 64'd5);
        check("t1_ba_const",  u_if.ba_ex_out1,        64'd100);
        idle_step();
        idle_step();

        // Two-wide streaming.
        step(1, 1, 2, 3, 0, 1, 64'h20, 64'h30, 0);
        step(1, 1, 4, 5, 1, 0, 64'h40, 64'h50, 0);
        idle_step();
        idle_step();

        // Slot 2 alone is compacted.
        step(0, 1, 0, 7, 0, 1, 64'd0, 64'h77, 0);
        idle_step();
        idle_step();

        // Flush with queue occupied and a completion offered in the same cycle.
        step(1, 1, 10, 11, 1, 1, 64'hA, 64'hB, 0);
        step(1, 0, 12, 0, 0, 0, 64'hC, 64'd0, 1);
        idle_step();

        // Sequential stream that wraps the pointers several times.
        k = 0;
        while (k < 16) begin
            two = (k < 15) && ($urandom_range(0, 1) == 1);
            if (two) begin
                step(1, 1, k, k + 1, 0, 1, 64'(k), 64'(k + 1), 0);
                k += 2;
            end else if ($urandom_range(0, 1) == 1) begin
                step(0, 1, 0, k, 0, 1, 64'd0, 64'(k), 0);
                k += 1;
            end else begin
                step(1, 0, k, 0, 1, 0, 64'(k), 64'd0, 0);
                k += 1;
            end
        end
        repeat (3) idle_step();

        // Randomized traffic with flushes and mid-stream async resets.
        for (int c = 0; c < 300; c++) begin
            rand_step(16);
            if (c % 97 == 50) pulse_reset();
        end

        // Boundary of cmp_ready and dropped completions while not ready.
        pulse_reset();
        force dut.r_count = 4'd6;
        #1 check("rdy_at6", 64'(u_if.cmp_ready), 64'd1);
        force dut.r_count = 4'd8;
        #1 check("rdy_at8", 64'(u_if.cmp_ready), 64'd0);
        force dut.r_count = 4'd7;
        #1 check("rdy_at7", 64'(u_if.cmp_ready), 64'd0);
        u_if.cmp1_valid   = 1'b1;
        u_if.cmp1_rob_idx = RI'(9);
        @(posedge clk);
        @(negedge clk);
        #1 check("drop_tail", 64'(dut.r_tail), 64'(m_tail));
        release dut.r_count;
        pulse_reset();
        repeat (40) rand_step(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
